// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : Pops bytes from a common-clock standard-mode FIFO and sends
//             each one as an asynchronous serial (UART) frame on TX.
//             Frame: start bit, 8 data bits LSB first, optional parity bit,
//             one or two stop bits. At most one FIFO read per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,  // clock cycles per serial bit, >= 2
    parameter int PARITY       = 0,    // 0 = none, 1 = even, 2 = odd
    parameter int STOP_BITS    = 1     // 1 or 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] FIFO_Dout,
    input  logic       FIFO_Empty,
    output logic       RD_EN,
    output logic       TX,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    // Baud counter sizing; counts 0 .. CLKS_PER_BIT-1 then wraps.
    localparam int              c_cnt_w    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

    // Index of the final stop bit (0 for one stop bit, 1 for two).
    localparam logic c_stop_last = (STOP_BITS == 2);

    // Odd parity is even parity inverted.
    localparam logic c_par_inv   = (PARITY == 2);
    localparam logic c_par_en    = (PARITY != 0);

    // State encoding.
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_wait   = 3'd1;
    localparam logic [2:0] c_st_start  = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_parity = 3'd4;
    localparam logic [2:0] c_st_stop   = 3'd5;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_shift;
    logic               r_par;
    logic               r_tx;

    logic               w_bit_end;
    logic               w_last_stop;

    // Bit-boundary and final-stop-bit decodes shared by the FSM and outputs.
    always_comb begin
        w_bit_end   = (r_cnt == c_cnt_last);
        w_last_stop = (r_stop_idx == c_stop_last);
    end

    // Frame sequencer: state, baud timing, shift register and serial line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // The read strobe goes out combinationally this cycle;
                    // the data arrives during WAIT.
                    r_tx <= 1'b1;
                    if (!FIFO_Empty) begin
                        r_state <= c_st_wait;
                    end
                end

                c_st_wait: begin
                    // Latch the popped byte and its parity, begin start bit.
                    r_shift    <= FIFO_Dout;
                    r_par      <= (^FIFO_Dout) ^ c_par_inv;
                    r_tx       <= 1'b0;
                    r_cnt      <= '0;
                    r_bit_idx  <= 3'd0;
                    r_stop_idx <= 1'b0;
                    r_state    <= c_st_start;
                end

                c_st_start: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= c_st_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_st_data: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            if (c_par_en) begin
                                r_tx    <= r_par;
                                r_state <= c_st_parity;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= c_st_stop;
                            end
                        end else begin
                            // Next bit is the one about to shift into bit 0.
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_st_parity: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= c_st_stop;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_st_stop: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_last_stop) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= c_st_idle;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_tx    <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode; the read strobe is masked during reset so no byte is
    // popped while the sequencer is held in IDLE.
    always_comb begin
        RD_EN      = (r_state == c_st_idle) && !FIFO_Empty && !RST;
        BUSY       = (r_state != c_st_idle);
        FRAME_DONE = (r_state == c_st_stop) && w_bit_end && w_last_stop;
        TX         = r_tx;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Purpose  : Directed self-checking bench for fifo_uart_tx. Three instances
//             with C = 4: (no parity, 1 stop), (even, 1 stop), (odd, 2 stop).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] empty;
    logic [2:0] rd_en;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] dout [3];

    // FIFO models
    logic [7:0] mem [3][16];
    int         push_cnt [3] = '{0, 0, 0};
    int         pop_cnt  [3] = '{0, 0, 0};
    logic [2:0] prev_rd = 3'b000;
    logic [2:0] force_e = 3'b000;
    logic       rand_on = 1'b0;
    int         rd_err  = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .CLK(clk), .RST(rst), .FIFO_Dout(dout[0]), .FIFO_Empty(empty[0]),
        .RD_EN(rd_en[0]), .TX(tx[0]), .BUSY(busy[0]), .FRAME_DONE(done[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .CLK(clk), .RST(rst), .FIFO_Dout(dout[1]), .FIFO_Empty(empty[1]),
        .RD_EN(rd_en[1]), .TX(tx[1]), .BUSY(busy[1]), .FRAME_DONE(done[1]));

    fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .CLK(clk), .RST(rst), .FIFO_Dout(dout[2]), .FIFO_Empty(empty[2]),
        .RD_EN(rd_en[2]), .TX(tx[2]), .BUSY(busy[2]), .FRAME_DONE(done[2]));

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        assign empty[g] = (push_cnt[g] == pop_cnt[g]) || force_e[g];
    end

    // Random empty flag on instance 0 while enabled.
    always @(posedge clk) begin
        force_e <= rand_on ? {2'b00, 1'($urandom_range(0, 1))} : 3'b000;
    end

    // FIFO read port plus read-protocol monitor.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_en[i]) begin
                if (empty[i])   rd_err = rd_err + 1;
                if (busy[i])    rd_err = rd_err + 1;
                if (prev_rd[i]) rd_err = rd_err + 1;
                dout[i]    <= mem[i][pop_cnt[i] % 16];
                pop_cnt[i] <= pop_cnt[i] + 1;
            end
            prev_rd[i] <= rd_en[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [7:0] b);
        mem[d][push_cnt[d] % 16] = b;
        push_cnt[d] = push_cnt[d] + 1;
    endtask

    // Leaves the bench in the cycle where RD_EN of instance d is high.
    task automatic wait_rd(input int d);
        bit found;
        found = 1'b0;
        #1;
        for (int k = 0; k < 200 && !found; k++) begin
            if (rd_en[d]) found = 1'b1;
            else step();
        end
        chk($sformatf("wait_rd%0d", d), {31'd0, found}, 32'd1);
    endtask

    // Checks one frame starting in the RD_EN cycle (cycle 0). Ends in the
    // first IDLE cycle after the frame; nxt = expected RD_EN there (2 = any).
    task automatic run_frame(input int d, input logic [7:0] b, input bit par_en,
                             input bit par_bit, input int stops, input int nxt);
        logic [15:0] bits;
        int          f;
        bits      = 16'hFFFF;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        f         = 9;
        if (par_en) begin
            bits[9] = par_bit;
            f       = 10;
        end
        f = f + stops;
        chk($sformatf("d%0d c0 busy", d), {31'd0, busy[d]}, 32'd0);
        for (int c = 1; c <= f * C + 2; c++) begin
            step();
            if (c == 1) begin
                chk($sformatf("d%0d wait tx", d),   {31'd0, tx[d]},   32'd1);
                chk($sformatf("d%0d wait busy", d), {31'd0, busy[d]}, 32'd1);
                chk($sformatf("d%0d wait rd", d),   {31'd0, rd_en[d]}, 32'd0);
            end else if (c <= f * C + 1) begin
                chk($sformatf("d%0d b%02h tx c%0d", d, b, c), {31'd0, tx[d]},
                    {31'd0, bits[(c - 2) / C]});
                chk($sformatf("d%0d done c%0d", d, c), {31'd0, done[d]},
                    {31'd0, c == f * C + 1});
                chk($sformatf("d%0d rd c%0d", d, c), {31'd0, rd_en[d] | ~busy[d]}, 32'd0);
            end else begin
                chk($sformatf("d%0d end busy", d), {31'd0, busy[d]}, 32'd0);
                chk($sformatf("d%0d end tx", d),   {31'd0, tx[d]},   32'd1);
                chk($sformatf("d%0d end done", d), {31'd0, done[d]}, 32'd0);
                if (nxt != 2)
                    chk($sformatf("d%0d next rd", d), {31'd0, rd_en[d]}, nxt);
            end
        end
    endtask

    initial begin
        // Reset, then idle with empty FIFOs.
        #1 rst = 1'b1;
        step(); step(); step();
        chk("rst tx",   {29'd0, tx},    32'd7);
        chk("rst rd",   {29'd0, rd_en}, 32'd0);
        chk("rst busy", {29'd0, busy},  32'd0);
        chk("rst done", {29'd0, done},  32'd0);
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            chk($sformatf("idle c%0d", k), {23'd0, tx, rd_en, busy}, {23'd0, 3'b111, 3'b000, 3'b000});
        end

        // Single byte 0xA5: frame 0,1,0,1,0,0,1,0,1,1; FRAME_DONE at cycle 41.
        push(0, 8'hA5);
        wait_rd(0);
        run_frame(0, 8'hA5, 1'b0, 1'b0, 1, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("quiet rd", {31'd0, rd_en[0]}, 32'd0);
        end

        // Back-to-back: RD_EN strobes exactly 42 cycles apart.
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        wait_rd(0);
        run_frame(0, 8'h00, 1'b0, 1'b0, 1, 1);
        run_frame(0, 8'hFF, 1'b0, 1'b0, 1, 1);
        run_frame(0, 8'h3C, 1'b0, 1'b0, 1, 0);

        // Even parity of 0x07 is 1.
        push(1, 8'h07);
        wait_rd(1);
        run_frame(1, 8'h07, 1'b1, 1'b1, 1, 0);

        // Odd parity of 0x07 is 0; two stop bits (8 high cycles).
        push(2, 8'h07);
        wait_rd(2);
        run_frame(2, 8'h07, 1'b1, 1'b0, 2, 0);

        // Empty flag toggling randomly during frames.
        rand_on = 1'b1;
        push(0, 8'h96);
        push(0, 8'h3C);
        wait_rd(0);
        run_frame(0, 8'h96, 1'b0, 1'b0, 1, 2);
        wait_rd(0);
        run_frame(0, 8'h3C, 1'b0, 1'b0, 1, 2);
        rand_on = 1'b0;
        step(); step();

        // Reset during data bit 3 of 0x55 (cycles 18..21); 0x81 follows clean.
        push(0, 8'h55);
        push(0, 8'h81);
        wait_rd(0);
        for (int k = 0; k < 19; k++) step();
        chk("pre-rst tx", {31'd0, tx[0]}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid-rst tx",   {31'd0, tx[0]},    32'd1);
        chk("mid-rst busy", {31'd0, busy[0]},  32'd0);
        chk("mid-rst rd",   {31'd0, rd_en[0]}, 32'd0);
        step(); step();
        chk("held-rst tx", {31'd0, tx[0]}, 32'd1);
        rst = 1'b0;
        wait_rd(0);
        run_frame(0, 8'h81, 1'b0, 1'b0, 1, 0);

        step(); step();
        chk("rd protocol errors", rd_err, 32'd0);
        for (int d = 0; d < 3; d++)
            chk($sformatf("d%0d drained", d), pop_cnt[d], push_cnt[d]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the byte FIFO: pops bytes from a common-clock standard-mode FIFO and sends each as an asynchronous serial (UART) frame on `TX`. It sits between the FIFO's read port (`Dout`, `Empty`, `RD_EN`) and the board serial pin. It issues at most one read per frame and never reads while the FIFO is empty.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit, minimum 2 (868 gives 115200 baud at 100 MHz).
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2 stop bits.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `FIFO_Dout`  in  8  FIFO read data, valid one cycle after `RD_EN`.
- `FIFO_Empty`  in  1  FIFO empty flag.
- `RD_EN`  out  1  FIFO read strobe, one cycle per popped byte.
- `TX`  out  1  serial line; idles high; registered.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `FRAME_DONE`  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - `RD_EN = !FIFO_Empty`, decoded combinationally from state and flag.
  - If `FIFO_Empty` = 0, go to WAIT; otherwise remain in IDLE.
- WAIT, one cycle:
  - `FIFO_Dout` is valid this cycle.
  - On the closing edge: shift register <= `FIFO_Dout`, `TX` <= 0, baud counter <= 0, go to START.
  - `FIFO_Empty` is ignored in WAIT.
- Every bit state lasts exactly `CLKS_PER_BIT` cycles, timed by the baud counter. The counter is `$clog2(CLKS_PER_BIT)` bits wide, counts 0..`CLKS_PER_BIT`-1, and wraps at the bit boundary.
- START: `TX` = 0.
- DATA:
  - 8 bits, LSB first, with a 3-bit index 0..7.
  - `TX` = shift register bit 0; shift right at each bit boundary.
  - After bit 7: go to PARITY if `PARITY` != 0, else to STOP.
- PARITY:
  - `TX` = XOR of the 8 data bits for even, inverted for odd.
  - The parity accumulator is computed from the byte latched in WAIT.
- STOP:
  - `TX` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles.
  - `FRAME_DONE` = 1 in the final cycle, then go to IDLE.
- Back-to-back frames: IDLE is entered with `TX` = 1 and may issue `RD_EN` in that same first IDLE cycle.
- Boundary rules:
  - `RD_EN` is never high while `FIFO_Empty` = 1.
  - `RD_EN` is never high outside IDLE.
  - `RD_EN` is never high for two consecutive cycles.
- FIFO becoming empty or non-empty mid-frame has no effect on the frame in progress.
- Reset mid-frame:
  - Immediate: `TX` = 1, state = IDLE, counters cleared.
  - The popped byte is discarded; no partial frame resumes after `RST` falls.

## Timing
- Reset values: `TX` = 1, `RD_EN` = 0, `BUSY` = 0, `FRAME_DONE` = 0, state IDLE, shift register 0, counters 0.
- Let cycle 0 be the IDLE cycle with `RD_EN` = 1, and C = `CLKS_PER_BIT`.
  - Cycle 1: WAIT.
  - Start bit: cycles 2..C+1.
  - Data bit k: cycles 2+(k+1)C .. 1+(k+2)C.
- Frame length F = 1 start + 8 data + (`PARITY` != 0) + `STOP_BITS`, in bits.
- `FRAME_DONE` is high at cycle 1+F·C; IDLE is reached at cycle 2+F·C.
- Steady-state period with a non-empty FIFO is F·C + 2 cycles.
- `BUSY` rises at cycle 1 and falls at cycle 2+F·C.

## Test plan
- Reset, then idle:
  - Hold `RST` for 3 cycles, then release with `FIFO_Empty` = 1 for 100 cycles.
  - Required: `TX` = 1, `RD_EN` = 0, `BUSY` = 0 throughout.
- Single byte, C = 4, no parity, 1 stop:
  - One byte 0xA5 in the FIFO.
  - Required: one `RD_EN` pulse; `TX` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting 2 cycles after `RD_EN`.
  - Required: `FRAME_DONE` at cycle 41; `RD_EN` never high again.
- Back-to-back, C = 4:
  - Bytes 0x00, 0xFF, 0x3C queued.
  - Required: `RD_EN` pulses exactly 42 cycles apart; decoded bytes 0x00, 0xFF, 0x3C; `TX` high in the IDLE/WAIT gap cycles.
- Parity and stop bits, C = 4:
  - `PARITY` = 1, byte 0x07 → parity bit 1.
  - `PARITY` = 2, byte 0x07 → parity bit 0.
  - `STOP_BITS` = 2 → `TX` high for 8 cycles before `FRAME_DONE` ends.
- Empty handling:
  - `FIFO_Empty` toggles randomly during frames; the FIFO model asserts an error on any read-while-empty.
  - Required: no error; `RD_EN` only in IDLE.
- Reset mid-frame:
  - Assert `RST` during DATA bit 3 of 0x55.
  - Required: `TX` = 1 asynchronously, before the next clock edge; `BUSY` = 0.
  - Required: after release, the next queued byte 0x81 is sent as a clean full frame.
